// File: rtl/biu_constants_pkg.sv
// Shared bus-interface types for the data-memory request queue and its users.
// Entry layout is fixed at 32-bit address/data for code that wants a named struct.
package biu_constants_pkg;

  localparam int BIU_XLEN = 32;

  typedef enum logic [1:0] {
    BIU_SIZE_BYTE  = 2'd0,
    BIU_SIZE_HALF  = 2'd1,
    BIU_SIZE_WORD  = 2'd2,
    BIU_SIZE_DWORD = 2'd3
  } biu_size_t;

  typedef struct packed {
    logic [BIU_XLEN-1:0] adr;
    logic [BIU_XLEN-1:0] d;
    logic                we;
    biu_size_t           size;
  } dmem_queue_entry_t;

  localparam int BIU_SIZE_W = $bits(biu_size_t);

endpackage

// File: rtl/riscv_dmem_fifo.sv
// Generic DEPTH-entry FIFO with registered full/empty/count flags.
// clear_i drops everything except an unpopped head, which stays as the only entry.
module riscv_dmem_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_push = push_i && !full_q && !clear_i;
  assign do_pop  = pop_i && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (clear_i) begin
      // A head that is still outstanding survives the clear as a single entry.
      if (!empty_q && !do_pop) begin
        wr_ptr_d = rd_ptr_q + PTR_ONE;
        count_d  = CNT_ONE;
      end else begin
        wr_ptr_d = rd_ptr_d;
        count_d  = '0;
      end
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CNT_FULL);
      empty_q  <= (count_d == '0);
    end
  end

  // Storage carries no reset; only slots behind the pointers are ever observed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/riscv_dmem_queue.sv
// In-order MEM-stage to dmem BIU request queue: one bus transaction outstanding,
// registered responses, and flush that squashes an already-issued head.
module riscv_dmem_queue
  import biu_constants_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_req_i,
  input  logic [XLEN-1:0]  mem_adr_i,
  input  logic [XLEN-1:0]  mem_d_i,
  input  logic             mem_we_i,
  input  biu_size_t        mem_size_i,
  output logic             mem_full_o,
  output logic             mem_empty_o,
  output logic [CNT_W-1:0] mem_count_o,
  output logic             mem_ack_o,
  output logic [XLEN-1:0]  mem_q_o,
  output logic             mem_err_o,
  input  logic             flush_i,
  output logic             dmem_req_o,
  output logic [XLEN-1:0]  dmem_adr_o,
  output logic [XLEN-1:0]  dmem_d_o,
  output logic             dmem_we_o,
  output biu_size_t        dmem_size_o,
  input  logic             dmem_ack_i,
  input  logic [XLEN-1:0]  dmem_q_i,
  input  logic             dmem_err_i
);

  localparam int SZ_W    = BIU_SIZE_W;
  localparam int ENTRY_W = 2 * XLEN + 1 + SZ_W;

  logic [ENTRY_W-1:0] push_entry, head;
  logic               full, empty;
  logic [CNT_W-1:0]   count;
  logic               push, pop;

  logic               squash_q, squash_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic [XLEN-1:0]    q_q, q_d;

  assign push       = mem_req_i && !full && !flush_i;
  assign pop        = dmem_ack_i && !empty;
  assign push_entry = {mem_adr_i, mem_d_i, mem_we_i, mem_size_i};

  riscv_dmem_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .clear_i (flush_i),
    .head_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  // The head slot is never rewritten while it is outstanding, so the bus stays stable.
  assign dmem_req_o  = !empty;
  assign dmem_adr_o  = empty ? '0 : head[ENTRY_W-1 -: XLEN];
  assign dmem_d_o    = empty ? '0 : head[SZ_W+XLEN -: XLEN];
  assign dmem_we_o   = empty ? 1'b0 : head[SZ_W];
  assign dmem_size_o = empty ? BIU_SIZE_BYTE : biu_size_t'(head[SZ_W-1:0]);

  always_comb begin
    squash_d = squash_q;
    if (pop) begin
      squash_d = 1'b0;
    end else if (flush_i && !empty) begin
      squash_d = 1'b1;
    end
    ack_d = pop && !squash_q && !flush_i;
    err_d = pop && dmem_err_i && !squash_q && !flush_i;
    q_d   = pop ? dmem_q_i : q_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      squash_q <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      q_q      <= '0;
    end else begin
      squash_q <= squash_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      q_q      <= q_d;
    end
  end

  assign mem_full_o  = full;
  assign mem_empty_o = empty;
  assign mem_count_o = count;
  assign mem_ack_o   = ack_q;
  assign mem_err_o   = err_q;
  assign mem_q_o     = q_q;

endmodule

// File: doc/riscv_dmem_queue.md
Name: riscv_dmem_queue

Overview:
Parametrised, in-order request queue between the core's MEM stage and the data-memory BIU port. It generalises the current single-request dmem handshake to DEPTH buffered requests, with occupancy status, registered responses and flush support. Exactly one bus transaction is outstanding at a time. The MEM stage stalls only on full rather than on every access.

Parameters:
XLEN, 32, address/data width
DEPTH, 4, queue entries; power of 2, >=2
CNT_W, $clog2(DEPTH+1), width of occupancy count (derived, not overridable)

Ports:
clk  in  1  clock
rst  in  1  reset
mem_req_i  in  1  push request from MEM stage
mem_adr_i  in  XLEN  request address
mem_d_i  in  XLEN  store data
mem_we_i  in  1  1=store, 0=load
mem_size_i  in  biu_size_t  access size
mem_full_o  out  1  queue full; push ignored
mem_empty_o  out  1  queue empty, no transaction pending
mem_count_o  out  CNT_W  entries held, including the entry on the bus
mem_ack_o  out  1  response pulse for oldest completed request
mem_q_o  out  XLEN  load data, valid with mem_ack_o
mem_err_o  out  1  bus error, valid with mem_ack_o
flush_i  in  1  discard queued requests
dmem_req_o  out  1  bus request
dmem_adr_o  out  XLEN  bus address
dmem_d_o  out  XLEN  bus write data
dmem_we_o  out  1  bus write enable
dmem_size_o  out  biu_size_t  bus access size
dmem_ack_i  in  1  bus acknowledge
dmem_q_i  in  XLEN  bus read data
dmem_err_i  in  1  bus error

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous, active-high.
- Reset values: mem_empty_o=1; mem_full_o=0; mem_count_o=0; mem_ack_o=0; mem_err_o=0; mem_q_o=0; dmem_req_o=0. dmem_adr_o/d_o/we_o/size_o reset to 0. Pointers reset to 0.
- Push: a push is accepted when mem_req_i=1, mem_full_o=0 and flush_i=0. The entry is written at wr_ptr and wr_ptr increments.
- When full, mem_req_i is ignored; the upstream holds the request.
- mem_full_o and mem_empty_o are registered, derived from the next count.
- Issue: dmem_req_o=1 whenever the queue is non-empty. Outputs are driven from the head entry.
- Latency: a push in cycle N gives dmem_req_o in cycle N+1.
- Bus hold rule: address, data, size and we stay stable while dmem_req_o=1 and dmem_ack_i=0.
- Completion: dmem_ack_i=1 pops the head.
- Response: in cycle N+1 after the ack, mem_ack_o=1 for one cycle. mem_q_o=dmem_q_i registered, mem_err_o=dmem_err_i registered. This applies to stores too; mem_q_o is don't-care for stores.
- Back-to-back: with >=2 entries, the next head drives the bus in the cycle after the ack. Sustained throughput is 1 request/cycle when the bus acks every cycle.
- Simultaneous push and pop: both take effect; count is unchanged. A push while full is not accepted, even if a pop occurs in the same cycle.
- Flush: all non-issued entries are dropped in the same cycle.
  - Head on bus, no ack this cycle: the head is retained (a bus request is never withdrawn) and marked squashed; count becomes 1.
  - Squashed head completion: its completion produces no mem_ack_o.
  - Ack in the same cycle as flush: head popped, count becomes 0, response suppressed.
  - Push in the same cycle as flush: discarded.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. count==DEPTH means full.
- Errors: the queue takes no action on an error beyond reporting it. Upstream flushes as required.
- Reset mid-transaction: the queue clears immediately and dmem_req_o drops. A late dmem_ack_i arriving while empty is ignored.

Decomposition:
- Shared package, biu_constants_pkg: dmem_queue_entry_t struct {adr, d, we, size} and biu_size_t.
- Sub-module riscv_dmem_fifo: generic DEPTH-entry FIFO (storage, pointers, count, full/empty) with push/pop/clear.
- The top handles bus issue, squash flag and response registers.

Test Plan:
- Single load: push adr=0x100 we=0; bus acks 2 cycles later with q=0xDEADBEEF -> dmem_req_o from cycle 1; mem_ack_o=1 and mem_q_o=0xDEADBEEF one cycle after ack; count 1->0.
- Fill DEPTH=4: push 5 requests with ack held low -> mem_full_o=1 after the 4th; the 5th is ignored; count=4; order on the bus matches push order after acks are released.
- Streaming: continuous pushes with ack every cycle -> 1 request/cycle, count stable at 1, pointers wrap past 3 without corruption over 20 requests.
- Flush with head pending: 3 queued, head on bus, flush_i=1 -> count=1, address held; the later ack yields mem_ack_o=0; queue empty.
- Flush coincident with ack and push -> count=0, no mem_ack_o, pushed entry discarded.
- Error: ack with dmem_err_i=1 -> mem_ack_o=1 and mem_err_o=1 next cycle. rst asserted mid-request -> dmem_req_o=0 immediately, empty=1.
